// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, immediate formats and the immediate generator.
package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] BR_LINK = 3'b111;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_t;

  function automatic imm_fmt_t imm_fmt(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: return IMM_I;
      OP_STORE:                                      return IMM_S;
      OP_BRANCH:                                     return IMM_B;
      OP_LUI, OP_AUIPC:                              return IMM_U;
      OP_JAL:                                        return IMM_J;
      default:                                       return IMM_NONE;
    endcase
  endfunction

  // 32-bit immediate; the caller sign-extends bit 31 to the datapath width.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_t fmt);
    case (fmt)
      IMM_I:   return {{20{instr[31]}}, instr[31:20]};
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   return {instr[31:12], 12'b0};
      IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_2w2r.sv
// Register file with writeback and link write ports and two write-through read ports.
module regfile_2w2r #(
  parameter int unsigned N = 64,
  parameter int unsigned NREG = 32,
  localparam int unsigned AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w_en,
  input  logic [AW-1:0] w_addr,
  input  logic [N-1:0]  w_data,
  input  logic          l_en,
  input  logic [AW-1:0] l_addr,
  input  logic [N-1:0]  l_data,
  input  logic [AW-1:0] r_addr1,
  output logic [N-1:0]  r_data1,
  input  logic [AW-1:0] r_addr2,
  output logic [N-1:0]  r_data2
);

  logic [N-1:0] mem_q [NREG];

  // Entry 0 is never written; the link port wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (l_en && l_addr == AW'(i)) begin
          mem_q[i] <= l_data;
        end else if (w_en && w_addr == AW'(i)) begin
          mem_q[i] <= w_data;
        end
      end
    end
  end

  always_comb begin
    r_data1 = mem_q[r_addr1];
    if (w_en && w_addr == r_addr1) r_data1 = w_data;
    if (l_en && l_addr == r_addr1) r_data1 = l_data;
    if (r_addr1 == '0) r_data1 = '0;
  end

  always_comb begin
    r_data2 = mem_q[r_addr2];
    if (w_en && w_addr == r_addr2) r_data2 = w_data;
    if (l_en && l_addr == r_addr2) r_data2 = l_data;
    if (r_addr2 == '0) r_data2 = '0;
  end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: register read, immediate generation, load-use interlock and D->E register.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int unsigned N = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned CNT_W = 32,
  localparam int unsigned AW = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_D,
  output logic             ready_D,
  input  logic [31:0]      instr_D,
  input  logic [N-1:0]     pc_D,
  input  logic [N-1:0]     pc4_D,
  input  logic [2:0]       branch_D,
  input  logic             regSel0_D,
  input  logic             memRead_D,
  input  logic             regWrite_W,
  input  logic [AW-1:0]    wa_W,
  input  logic [N-1:0]     wd_W,
  input  logic             flush,
  input  logic             ready_E,
  output logic             valid_E,
  output logic [AW-1:0]    rs1_E,
  output logic [AW-1:0]    rs2_E,
  output logic [AW-1:0]    rd_E,
  output logic             memRead_E,
  output logic [N-1:0]     readData1_E,
  output logic [N-1:0]     readData2_E,
  output logic [N-1:0]     signImm_E,
  output logic [N-1:0]     pc_E,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [AW-1:0] rs1, rs2, rd;
  logic [N-1:0]  rd1, rd2, imm;
  logic [31:0]   imm32;
  logic          hz, adv, link_we;

  assign rs1 = regSel0_D ? '0 : AW'(instr_D[19:15]);
  assign rs2 = AW'(instr_D[24:20]);
  assign rd  = AW'(instr_D[11:7]);

  assign imm32 = imm_gen(instr_D, imm_fmt(instr_D[6:0]));
  assign imm   = {{(N-32){imm32[31]}}, imm32};

  // Load in E whose result a valid D instruction needs: insert one bubble.
  assign hz = valid_E & memRead_E & (rd_E != '0) & ((rd_E == rs1) | (rd_E == rs2)) & valid_D;
  assign ready_D = ready_E & ~hz;
  assign adv     = valid_D & ready_D;
  assign link_we = valid_D & (branch_D == BR_LINK) & adv & (rd != '0);

  regfile_2w2r #(
    .N    (N),
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .w_en    (regWrite_W),
    .w_addr  (wa_W),
    .w_data  (wd_W),
    .l_en    (link_we),
    .l_addr  (rd),
    .l_data  (pc4_D),
    .r_addr1 (rs1),
    .r_data1 (rd1),
    .r_addr2 (rs2),
    .r_data2 (rd2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_E     <= 1'b0;
      rs1_E       <= '0;
      rs2_E       <= '0;
      rd_E        <= '0;
      memRead_E   <= 1'b0;
      readData1_E <= '0;
      readData2_E <= '0;
      signImm_E   <= '0;
      pc_E        <= '0;
      stall_cnt   <= '0;
    end else if (flush) begin
      valid_E <= 1'b0;
    end else if (ready_E) begin
      if (hz) begin
        valid_E <= 1'b0;
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        valid_E     <= valid_D;
        rs1_E       <= rs1;
        rs2_E       <= rs2;
        rd_E        <= rd;
        memRead_E   <= memRead_D;
        readData1_E <= rd1;
        readData2_E <= rd2;
        signImm_E   <= imm;
        pc_E        <= pc_D;
      end
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: directed instructions, monitor checks each E handshake.
module tb_decode_pipe;

  localparam int unsigned N = 64;
  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic         mr;
    logic [N-1:0] d1;
    logic [N-1:0] d2;
    logic [N-1:0] imm;
    logic [N-1:0] pc;
  } e_t;

  logic clk = 1'b0;
  logic rst_n;
  logic valid_D, ready_D, regSel0_D, memRead_D, regWrite_W, flush, ready_E;
  logic [31:0] instr_D;
  logic [N-1:0] pc_D, pc4_D, wd_W;
  logic [2:0] branch_D;
  logic [4:0] wa_W;
  logic valid_E, memRead_E;
  logic [4:0] rs1_E, rs2_E, rd_E;
  logic [N-1:0] readData1_E, readData2_E, signImm_E, pc_E;
  logic [CNT_W-1:0] stall_cnt;

  int n_pass = 0;
  int n_total = 0;
  e_t q[$];

  always #5 clk = ~clk;

  decode_pipe #(.N(N), .NREG(32), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_D     (valid_D),
    .ready_D     (ready_D),
    .instr_D     (instr_D),
    .pc_D        (pc_D),
    .pc4_D       (pc4_D),
    .branch_D    (branch_D),
    .regSel0_D   (regSel0_D),
    .memRead_D   (memRead_D),
    .regWrite_W  (regWrite_W),
    .wa_W        (wa_W),
    .wd_W        (wd_W),
    .flush       (flush),
    .ready_E     (ready_E),
    .valid_E     (valid_E),
    .rs1_E       (rs1_E),
    .rs2_E       (rs2_E),
    .rd_E        (rd_E),
    .memRead_E   (memRead_E),
    .readData1_E (readData1_E),
    .readData2_E (readData2_E),
    .signImm_E   (signImm_E),
    .pc_E        (pc_E),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic e_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic mr, input logic [N-1:0] d1, input logic [N-1:0] d2,
                            input logic [N-1:0] imm, input logic [N-1:0] pc);
    e_t e;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.mr = mr;
    e.d1 = d1; e.d2 = d2; e.imm = imm; e.pc = pc;
    return e;
  endfunction

  // Monitor: every handshake on the E side must match the oldest expected entry.
  initial begin
    e_t act, exp;
    forever begin
      @(negedge clk);
      if (rst_n && valid_E && ready_E) begin
        act = mk(rs1_E, rs2_E, rd_E, memRead_E, readData1_E, readData2_E, signImm_E, pc_E);
        n_total++;
        if (q.size() == 0) begin
          $display("FAIL e_unexpected: got %h expected no output", act);
        end else begin
          exp = q.pop_front();
          if (act === exp) n_pass++;
          else $display("FAIL e_out pc=%h: got %h expected %h", exp.pc, act, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Starts and ends just after a rising edge.
  task automatic send(input logic [31:0] ins, input logic [N-1:0] pc, input logic [2:0] br,
                      input logic sel0, input logic mr, input e_t exp);
    bit ok = 1'b0;
    instr_D = ins; pc_D = pc; pc4_D = pc + 4; branch_D = br;
    regSel0_D = sel0; memRead_D = mr; valid_D = 1'b1;
    q.push_back(exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready_D) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_accept", {63'b0, ok}, 1);
    @(posedge clk); #1;
    valid_D = 1'b0; branch_D = 3'b0; regSel0_D = 1'b0; memRead_D = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [N-1:0] d);
    regWrite_W = 1'b1; wa_W = a; wd_W = d;
    @(posedge clk); #1;
    regWrite_W = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; valid_D = 1'b0; instr_D = '0; pc_D = '0; pc4_D = '0; branch_D = '0;
    regSel0_D = 1'b0; memRead_D = 1'b0; regWrite_W = 1'b0; wa_W = '0; wd_W = '0;
    flush = 1'b0; ready_E = 1'b1;

    // Power-on reset
    repeat (2) @(negedge clk);
    chk("rst_valid_E", {63'b0, valid_E}, 0);
    chk("rst_stall_cnt", N'(stall_cnt), 0);
    chk("rst_readData1", readData1_E, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    wb(5'd5, 64'h5555);
    wb(5'd2, 64'h22);

    // Same-cycle writeback bypass into the read port
    regWrite_W = 1'b1; wa_W = 5'd3; wd_W = 64'hDEAD;
    send(32'h00018493, 64'h100, 3'b0, 1'b0, 1'b0, mk(3, 0, 9, 0, 64'hDEAD, 0, 0, 64'h100));
    regWrite_W = 1'b0;

    // Load-use: one bubble, ready_D low for exactly one cycle
    send(32'h0002B383, 64'h104, 3'b0, 1'b0, 1'b1, mk(5, 0, 7, 1, 64'h5555, 0, 0, 64'h104));
    instr_D = 32'h002380B3; pc_D = 64'h108; valid_D = 1'b1;
    q.push_back(mk(7, 2, 1, 0, 0, 64'h22, 0, 64'h108));
    @(negedge clk);
    chk("hz_ready_D", {63'b0, ready_D}, 0);
    @(negedge clk);
    chk("hz_bubble_valid_E", {63'b0, valid_E}, 0);
    chk("hz_stall_cnt", N'(stall_cnt), 1);
    chk("hz_ready_D_release", {63'b0, ready_D}, 1);
    @(posedge clk); #1;
    valid_D = 1'b0;

    // Link write beats the W port on the same register; x0 stays zero
    regWrite_W = 1'b1; wa_W = 5'd1; wd_W = 64'h55;
    send(32'h000000EF, 64'h1000, 3'b111, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 64'h1000));
    regWrite_W = 1'b0;
    send(32'h00008533, 64'h1004, 3'b0, 1'b0, 1'b0, mk(1, 0, 10, 0, 64'h1004, 0, 0, 64'h1004));
    send(32'h0000006F, 64'h2000, 3'b111, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 64'h2000));
    send(32'h000005B3, 64'h2004, 3'b0, 1'b0, 1'b0, mk(0, 0, 11, 0, 0, 0, 0, 64'h2004));

    // E back-pressure for three cycles: outputs held, D blocked
    send(32'h123452B7, 64'h200, 3'b0, 1'b1, 1'b0,
         mk(0, 3, 5, 0, 0, 64'hDEAD, 64'h12345000, 64'h200));
    ready_E = 1'b0;
    instr_D = 32'h00018493; pc_D = 64'h204; valid_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_ready_D", {63'b0, ready_D}, 0);
      chk("hold_valid_E", {63'b0, valid_E}, 1);
      chk("hold_pc_E", pc_E, 64'h200);
      chk("hold_signImm_E", signImm_E, 64'h12345000);
    end
    @(posedge clk); #1;
    ready_E = 1'b1;
    q.push_back(mk(3, 0, 9, 0, 64'hDEAD, 0, 0, 64'h204));
    @(posedge clk); #1;
    valid_D = 1'b0;

    // Flush coincident with a load-use hazard: no stall count
    send(32'h0002B383, 64'h300, 3'b0, 1'b0, 1'b1, mk(5, 0, 7, 1, 64'h5555, 0, 0, 64'h300));
    instr_D = 32'h002380B3; pc_D = 64'h304; valid_D = 1'b1; flush = 1'b1;
    q.push_back(mk(7, 2, 1, 0, 0, 64'h22, 0, 64'h304));
    @(negedge clk);
    chk("flush_hz_ready_D", {63'b0, ready_D}, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid_E", {63'b0, valid_E}, 0);
    chk("flush_stall_cnt", N'(stall_cnt), 1);
    @(posedge clk); #1;
    valid_D = 1'b0;

    // Immediate formats
    send(32'hFFF00093, 64'h400, 3'b0, 1'b0, 1'b0, mk(0, 31, 1, 0, 0, 0, '1, 64'h400));
    send(32'hFE000CE3, 64'h404, 3'b0, 1'b0, 1'b0,
         mk(0, 0, 25, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h404));
    send(32'h0020A423, 64'h408, 3'b0, 1'b0, 1'b0, mk(1, 2, 8, 0, 64'h1004, 64'h22, 8, 64'h408));

    // Reset while an instruction sits in E
    instr_D = 32'h00528333; pc_D = 64'h500; valid_D = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_E", {63'b0, valid_E}, 0);
    chk("midrst_stall_cnt", N'(stall_cnt), 0);
    valid_D = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid_E", {63'b0, valid_E}, 0);
    send(32'h00528333, 64'h600, 3'b0, 1'b0, 1'b0, mk(5, 5, 6, 0, 0, 0, 0, 64'h600));

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", N'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
